// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, command codes and width defaults for the SPI slave
package spi_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int WORD_W_DEF = 10;
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;
   // cmd is {first mosi bit, rd_addr_done}: a read is an address read until the address has been taken
   function automatic state_t cmd_state(input logic [1:0] cmd);
      return cmd == CMD_RD_DATA ? READ_DATA :
             cmd == CMD_RD_ADDR ? READ_ADD  :
             cmd inside {CMD_WR_ADDR, CMD_WR_DATA} ? WRITE : IDLE;
   endfunction
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: serial-in word assembler and serial-out read byte shifter with their bit counters
module spi_shift_reg
   import spi_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              sh_in,
   input  logic              cnt_en,
   input  logic              mosi,
   input  logic              load,
   input  logic [DATA_W-1:0] tx_data,
   output logic [WORD_W-1:0] word_nxt,
   output logic [3:0]        cnt,
   output logic              tx_busy,
   output logic              tx_last,
   output logic              miso
);
   logic [WORD_W-1:0] sr_q, sr_d;
   logic [3:0] cnt_q, cnt_d, tx_cnt_q, tx_cnt_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   always_comb begin
      word_nxt = {sr_q[WORD_W-2:0], mosi};
      sr_d = sh_in ? word_nxt : sr_q;
      cnt_d = clr ? 4'd0 : cnt_en ? cnt_q + 4'd1 : cnt_q;
      tx_d = load ? tx_data : tx_cnt_q != 4'd0 ? tx_q << 1 : tx_q;
      tx_cnt_d = clr ? 4'd0 : load ? 4'(DATA_W) : tx_cnt_q != 4'd0 ? tx_cnt_q - 4'd1 : 4'd0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '0;
         cnt_q <= 4'd0;
         tx_q <= '0;
         tx_cnt_q <= 4'd0;
      end else begin
         sr_q <= sr_d;
         cnt_q <= cnt_d;
         tx_q <= tx_d;
         tx_cnt_q <= tx_cnt_d;
      end
   end
   assign cnt = cnt_q;
   assign tx_busy = tx_cnt_q != 4'd0;
   assign tx_last = tx_cnt_q == 4'd1;
   assign miso = tx_busy & tx_q[DATA_W-1];
endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front end assembling 10-bit RAM commands and returning read bytes on miso
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid
);
   state_t state_q, state_d;
   logic rx_valid_q, rx_valid_d, rd_done_q, rd_done_d;
   logic [WORD_W-1:0] rx_data_q, rx_data_d, word_nxt;
   logic [3:0] cnt;
   logic rx_phase, word_done, sh_in, load, clr, tx_busy, tx_last;
   spi_shift_reg #(.DATA_W(DATA_W), .WORD_W(WORD_W)) u_sr (
      .clk(clk), .rst(rst), .clr(clr), .sh_in(sh_in), .cnt_en(rx_phase), .mosi(mosi),
      .load(load), .tx_data(tx_data), .word_nxt(word_nxt), .cnt(cnt),
      .tx_busy(tx_busy), .tx_last(tx_last), .miso(miso)
   );
   // cnt reaching WORD_W-1 marks a finished word; the state then idles until ss_n rises
   always_comb begin
      rx_phase = !ss_n && state_q inside {WRITE, READ_ADD, READ_DATA} && cnt != 4'(WORD_W-1);
      word_done = rx_phase && cnt == 4'(WORD_W-2);
      sh_in = rx_phase || (!ss_n && state_q == CHK_CMD);
      load = !ss_n && tx_valid && state_q == READ_DATA && cnt == 4'(WORD_W-1) && !tx_busy && rd_done_q;
      clr = ss_n || state_q == IDLE;
      rx_valid_d = word_done;
      rx_data_d = word_done ? word_nxt : rx_data_q;
      rd_done_d = tx_last ? 1'b0 : (word_done && state_q == READ_ADD) ? 1'b1 : rd_done_q;
      state_d = ss_n ? IDLE :
                state_q == IDLE ? CHK_CMD :
                state_q == CHK_CMD ? cmd_state({mosi, rd_done_q}) : state_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rx_valid_q <= 1'b0;
         rx_data_q <= '0;
         rd_done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q <= rx_data_d;
         rd_done_q <= rd_done_d;
      end
   end
   assign rx_data = rx_data_q;
   assign rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: transaction-level model of the SPI slave checked against the DUT every cycle
module tb_spi_slave_if;
   logic clk = 1'b0, rst, ss_n, mosi, miso, rx_valid, tx_valid;
   logic [9:0] rx_data, rv_dat = '0, m_rx = '0;
   logic [7:0] tx_data, got;
   int cyc = 0, total = 0, bad = 0, n_rv = 0, rv_cyc = -1, miso_ones = 0;
   int c0, k, ones0, nrv0;
   bit chk_on = 0, m_done = 0;
   bit rv_at[int];
   logic [9:0] rx_at[int];
   bit exp_miso[int];
   bit miso_log[int];
   logic [9:0] rw;
   int rnb, rm, rdly;
   bit rrst;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_slave_if dut (
      .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .miso(miso),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      miso_log[cyc] = miso;
      if (miso === 1'b1) miso_ones++;
      if (rx_valid === 1'b1) begin
         n_rv++;
         rv_cyc = cyc;
         rv_dat = rx_data;
      end
      if (chk_on) begin
         if (rx_at.exists(cyc)) m_rx = rx_at[cyc];
         check("rx_valid", rx_valid, rv_at.exists(cyc));
         check("rx_data", rx_data, m_rx);
         check("miso", miso, exp_miso.exists(cyc) ? exp_miso[cyc] : 1'b0);
      end
   end

   // One ss_n frame: nb command bits (10 = complete word), then a RAM reply tx_dly cycles after the
   // strobe and a hold of m cycles past the reply before ss_n rises (or rst pulses with it).
   task automatic frame(input logic [9:0] w, input int nb, input bit use_rst, input int tx_dly,
                        input logic [7:0] b, input int m, output int fc0, output int fk);
      bit rdata;
      rdata = w[9] && m_done;
      fk = -1;
      fc0 = cyc;
      ss_n = 1'b0;
      mosi = 1'($urandom);
      tick();
      for (int i = 9; i > 9 - nb; i--) begin
         mosi = w[i];
         tx_valid = 1'($urandom);
         tick();
      end
      tx_valid = 1'b0;
      mosi = 1'($urandom);
      if (nb == 10) begin
         rv_at[cyc] = 1'b1;
         rx_at[cyc] = w;
         if (w[9] && !rdata) m_done = 1'b1;
         repeat (tx_dly) tick();
         tx_valid = 1'b1;
         tx_data = b;
         fk = cyc;
         if (rdata) for (int i = 0; i < 8 && i < m; i++) exp_miso[fk + 1 + i] = b[7 - i];
         if (rdata && m >= 8) m_done = 1'b0;
         tick();
         while (cyc < fk + m) begin
            tx_valid = 1'($urandom);
            tx_data = 8'($urandom);
            tick();
         end
         tx_valid = 1'b0;
      end
      rst = use_rst;
      ss_n = 1'b1;
      tick();
      rst = 1'b0;
      if (use_rst) begin
         rx_at[cyc] = '0;
         m_done = 1'b0;
      end
   endtask

   task automatic read_byte(input int fk, output logic [7:0] v);
      for (int i = 0; i < 8; i++) v[7 - i] = miso_log[fk + 1 + i];
   endtask

   initial begin
      rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_rx_data", rx_data, 0);
      check("reset_miso", miso, 0);
      chk_on = 1'b1;

      frame(10'h015, 10, 0, 1, 8'h00, 3, c0, k);
      check("wa_latency", rv_cyc - c0, 11);
      check("wa_data", rv_dat, 10'h015);

      nrv0 = n_rv; ones0 = miso_ones;
      frame(10'h1A5, 10, 0, 2, 8'hFF, 4, c0, k);
      check("wd_data", rv_dat, 10'h1A5);
      check("wd_strobes", n_rv - nrv0, 1);
      check("wd_miso_quiet", miso_ones - ones0, 0);

      frame(10'h215, 10, 0, 1, 8'hFF, 2, c0, k);
      check("ra_data", rv_dat, 10'h215);
      frame(10'h300, 10, 0, 2, 8'h3C, 9, c0, k);
      read_byte(k, got);
      check("rd_byte", got, 8'h3C);
      check("rd_data", rv_dat, 10'h300);
      ones0 = miso_ones;
      frame(10'h300, 10, 0, 2, 8'hFF, 9, c0, k);
      check("rd_done_cleared", miso_ones - ones0, 0);

      nrv0 = n_rv;
      frame(10'h0F0, 5, 0, 1, 8'h00, 1, c0, k);
      check("abort_no_strobe", n_rv - nrv0, 0);
      frame(10'h0C3, 10, 0, 1, 8'h00, 1, c0, k);
      check("after_abort_data", rv_dat, 10'h0C3);

      ones0 = miso_ones;
      frame(10'h355, 10, 0, 1, 8'hFF, 3, c0, k);
      check("midshift_bits", miso_ones - ones0, 3);
      frame(10'h300, 10, 0, 2, 8'h81, 9, c0, k);
      read_byte(k, got);
      check("midshift_retry", got, 8'h81);

      frame(10'h215, 10, 0, 1, 8'h00, 1, c0, k);
      frame(10'h3AA, 5, 1, 1, 8'h00, 1, c0, k);
      @(negedge clk);
      check("rst_rx_data", rx_data, 0);
      check("rst_miso", miso, 0);
      frame(10'h255, 5, 1, 1, 8'h00, 1, c0, k);
      @(negedge clk);
      check("rst_ra_rx_valid", rx_valid, 0);
      ones0 = miso_ones;
      frame(10'h300, 10, 0, 2, 8'hFF, 9, c0, k);
      check("rst_next_read_addr", miso_ones - ones0, 0);

      for (int t = 0; t < 160; t++) begin
         rw = 10'($urandom);
         rnb = $urandom_range(0, 9) < 7 ? 10 : $urandom_range(0, 9);
         rrst = rnb < 10 && $urandom_range(0, 4) == 0;
         rdly = $urandom_range(1, 3);
         rm = $urandom_range(1, 10);
         frame(rw, rnb, rrst, rdly, 8'($urandom), rm, c0, k);
         repeat ($urandom_range(0, 2)) tick();
      end
      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spi_slave_if.md
SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
REQ-001 Parameter DATA_W, default 8: width of the RAM data/address byte.
REQ-002 Parameter WORD_W, default 10: width of the received command word (2 command bits + DATA_W).
REQ-003 Port list, in this order:
- clk, input, 1: single clock, also the SPI bit clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- ss_n, input, 1: slave select, active low.
- mosi, input, 1: serial data in, MSB first.
- miso, output, 1: serial data out, MSB first.
- rx_data, output, WORD_W: assembled command word sent to the RAM.
- rx_valid, output, 1: one-cycle strobe qualifying rx_data.
- tx_data, input, DATA_W: read byte returned by the RAM.
- tx_valid, input, 1: qualifies tx_data.

Function
REQ-004 The FSM shall have five states: IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-005 In IDLE with ss_n=0, the FSM shall go to CHK_CMD on the next cycle; no bit is sampled in that cycle.
REQ-006 In CHK_CMD, mosi shall be sampled as word bit 9, with the following next state:
- mosi=0: WRITE.
- mosi=1 and rd_addr_done=0: READ_ADD.
- mosi=1 and rd_addr_done=1: READ_DATA.
REQ-007 In WRITE, READ_ADD and READ_DATA, the block shall shift in 9 further bits (bits 8..0), one per cycle; a 4-bit counter shall count the bits.
REQ-008 The cycle after bit 0 is sampled, rx_valid shall be 1 for exactly one cycle, with rx_data equal to the full 10-bit word.
REQ-009 rx_data shall hold its value until the next word completes.
REQ-010 rx_data shall be forwarded unchanged, even if bits 9..8 do not match the current state.
REQ-011 When a READ_ADD word completes, rd_addr_done shall be set to 1, and the FSM shall wait in READ_ADD until ss_n=1.
REQ-012 When a WRITE word completes, the FSM shall wait in WRITE until ss_n=1.
REQ-013 In READ_DATA, after its rx_valid strobe, the block shall wait for tx_valid=1 and capture tx_data in that cycle.
REQ-014 Starting the cycle after capture, miso shall drive tx_data[7] down to tx_data[0], one bit per cycle, over 8 consecutive cycles.
REQ-015 rd_addr_done shall clear after the 8th bit is driven.
REQ-016 miso shall be 0 whenever it is not driving a read byte.
REQ-017 ss_n=1 in any state shall force IDLE on the next cycle, clear the bit counter and abandon any partial word, with no rx_valid strobe.
REQ-018 ss_n=1 shall not alter rd_addr_done unless the read byte has been fully shifted.
REQ-019 A tx_valid pulse received outside READ_DATA-wait shall be ignored.
REQ-020 If ss_n rises during the miso shift, the shift shall stop and rd_addr_done shall stay 1, so the next read retries READ_DATA.
REQ-021 ss_n low in the same cycle that a previous transaction's IDLE is entered shall be handled by REQ-005 on the following cycle.

Reset
REQ-022 When rst=1 at a rising clk edge, all of the following shall take their reset values at that edge, overriding all inputs:
- state = IDLE
- rx_valid = 0
- rx_data = 0
- miso = 0
- rd_addr_done = 0
- bit counter = 0
- captured byte = 0
REQ-023 Reset asserted mid-transaction shall discard the transaction, and no rx_valid strobe shall follow.

Structure
REQ-024 A shared package spi_pkg shall hold the state encoding constants (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA), the command codes (00 write-addr, 01 write-data, 10 read-addr, 11 read-data), and WORD_W/DATA_W defaults.
REQ-025 One sub-module, spi_shift_reg, shall hold the serial-in/parallel-out and parallel-in/serial-out shift register with its bit counter; the FSM shall remain in spi_slave_if.

Verification
REQ-026 Write-address: ss_n=0, mosi bits 0,0,0x15 (8 bits) -> rx_valid one cycle with rx_data=10'h015, 11 cycles after ss_n falls.
REQ-027 Write-data: mosi 0,1,0xA5 -> rx_data=10'h1A5, single strobe; miso stays 0 throughout.
REQ-028 Read sequence: read-addr 1,0,0x15, then ss_n=1, then read-data 1,1,0x00; tb returns tx_valid with tx_data=0x3C two cycles after the strobe -> miso carries 0,0,1,1,1,1,0,0 over the next 8 cycles; rd_addr_done then returns to 0.
REQ-029 Abort: ss_n rises after 5 bits of a write -> no rx_valid; the next full write is received correctly.
REQ-030 Mid-shift abort: ss_n rises after 3 miso bits -> the next read command enters READ_DATA, not READ_ADD.
REQ-031 Reset: rst=1 during READ_ADD bit 4 -> all outputs 0, state IDLE, and the next read goes to READ_ADD.
